// File: rtl/cp0_tlb_ctrl.sv
// cp0_tlb_ctrl: CP0-side initiator for the MMU TLB maintenance port.
// Holds Index/Random/Wired/EntryHi/EntryLo0/EntryLo1/PageMask/BadVAddr,
// sequences TLBR/TLBWI/TLBWR/TLBP towards the MMU and captures MMU fault
// reports. Handshake outputs are registered; Mfc0_Data is combinational.
module cp0_tlb_ctrl #(
  parameter int ACK_TIMEOUT = 15,
  parameter int RANDOM_TOP  = 7
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Op_Valid,
  input  logic [1:0]  Op_Code,
  input  logic        Mtc0_En,
  input  logic [2:0]  Mtc0_Sel,
  input  logic [31:0] Mtc0_Data,
  input  logic [2:0]  Mfc0_Sel,
  output logic [31:0] Mfc0_Data,
  output logic        Op_Busy,
  output logic        Op_Done,
  output logic        Op_Err,
  output logic        CP0_RdReq,
  output logic        CP0_WrReq,
  output logic [1:0]  CP0_MMU_Func,
  output logic [2:0]  CP0_MMU_Index,
  output logic [31:0] CP0_EntryHi,
  output logic [31:0] CP0_EntryLo0,
  output logic [31:0] CP0_EntryLo1,
  output logic [31:0] CP0_PageMask,
  output logic [7:0]  CP0_ASID,
  input  logic        MMU_CP0_AckR,
  input  logic        MMU_CP0_AckP,
  input  logic        MMU_CP0_Matched,
  input  logic [2:0]  MMU_CP0_Index,
  input  logic [31:0] MMU_CP0_EntryHi,
  input  logic [31:0] MMU_CP0_EntryLo0,
  input  logic [31:0] MMU_CP0_EntryLo1,
  input  logic [31:0] MMU_CP0_PageMask,
  input  logic        MMU_CP0_Req,
  input  logic [31:0] MMU_CP0_BadVAddr
);

  localparam logic [2:0] LP_RTOP = 3'(RANDOM_TOP);
  localparam logic [3:0] LP_TMO  = 4'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_PR_WAIT,
    S_WR,
    S_DONE
  } state_t;

  // Architectural field masks: unimplemented bits always read as zero.
  function automatic logic [31:0] f_mask_hi(input logic [31:0] d);
    return d & 32'hFFFF_E0FF;
  endfunction

  function automatic logic [31:0] f_mask_lo(input logic [31:0] d);
    return d & 32'h03FF_FFFF;
  endfunction

  function automatic logic [31:0] f_mask_pm(input logic [31:0] d);
    return d & 32'h1FFF_E000;
  endfunction

  state_t      r_state;
  logic        r_rdreq;
  logic        r_wrreq;
  logic [1:0]  r_func;
  logic [2:0]  r_mmu_idx;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        r_tmo;
  logic [3:0]  r_cnt;

  logic        r_p;
  logic [2:0]  r_idx;
  logic [2:0]  r_random;
  logic [2:0]  r_wired;
  logic [31:0] r_hi;
  logic [31:0] r_lo0;
  logic [31:0] r_lo1;
  logic [31:0] r_pm;
  logic [31:0] r_bv;

  logic        w_mtc0_ok;
  logic        w_wired_wr;
  logic        w_ack;
  logic        w_rd_ack;
  logic        w_pr_ack;
  logic [3:0]  w_cnt_nxt;

  // Register writes are only honoured while no TLB instruction is in flight.
  assign w_mtc0_ok  = Mtc0_En && (r_state == S_IDLE);
  assign w_wired_wr = w_mtc0_ok && (Mtc0_Sel == 3'd5);
  assign w_rd_ack   = (r_state == S_RD_WAIT) && MMU_CP0_AckR;
  assign w_pr_ack   = (r_state == S_PR_WAIT) && MMU_CP0_AckP;
  assign w_ack      = w_rd_ack || w_pr_ack;
  assign w_cnt_nxt  = r_cnt + 4'd1;

  // Instruction sequencer with registered MMU handshake and completion outputs.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_rdreq   <= 1'b0;
      r_wrreq   <= 1'b0;
      r_func    <= 2'b00;
      r_mmu_idx <= 3'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_tmo     <= 1'b0;
      r_cnt     <= 4'd0;
    end else begin
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_wrreq <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Op_Valid) begin
            r_busy <= 1'b1;
            r_cnt  <= 4'd0;
            case (Op_Code)
              2'b00: begin
                r_state   <= S_RD_WAIT;
                r_rdreq   <= 1'b1;
                r_func    <= 2'b01;
                r_mmu_idx <= r_idx;
              end
              2'b11: begin
                r_state <= S_PR_WAIT;
                r_rdreq <= 1'b1;
                r_func  <= 2'b10;
              end
              2'b01: begin
                r_state   <= S_WR;
                r_mmu_idx <= r_idx;
              end
              default: begin
                r_state   <= S_WR;
                r_mmu_idx <= r_random;
              end
            endcase
          end
        end
        S_RD_WAIT, S_PR_WAIT: begin
          if (w_ack) begin
            r_rdreq <= 1'b0;
            r_func  <= 2'b00;
            r_state <= S_DONE;
          end else if (w_cnt_nxt == LP_TMO) begin
            // No answer from the MMU: abandon the request, flag it at completion.
            r_rdreq <= 1'b0;
            r_func  <= 2'b00;
            r_tmo   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_WR: begin
          r_wrreq <= 1'b1;
          r_func  <= 2'b11;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_func  <= 2'b00;
          r_done  <= 1'b1;
          r_err   <= r_tmo;
          r_tmo   <= 1'b0;
          r_busy  <= 1'b0;
          r_cnt   <= 4'd0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // CP0 register file: Mtc0 writes, TLBR/TLBP results, then fault capture last so it wins on EntryHi.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_p     <= 1'b0;
      r_idx   <= 3'd0;
      r_wired <= 3'd0;
      r_hi    <= 32'd0;
      r_lo0   <= 32'd0;
      r_lo1   <= 32'd0;
      r_pm    <= 32'd0;
      r_bv    <= 32'd0;
    end else begin
      if (w_mtc0_ok) begin
        case (Mtc0_Sel)
          3'd0:    r_idx   <= Mtc0_Data[2:0];
          3'd2:    r_lo0   <= f_mask_lo(Mtc0_Data);
          3'd3:    r_lo1   <= f_mask_lo(Mtc0_Data);
          3'd4:    r_pm    <= f_mask_pm(Mtc0_Data);
          3'd5:    r_wired <= Mtc0_Data[2:0];
          3'd7:    r_hi    <= f_mask_hi(Mtc0_Data);
          default: ;
        endcase
      end
      if (w_rd_ack) begin
        r_hi  <= f_mask_hi(MMU_CP0_EntryHi);
        r_lo0 <= f_mask_lo(MMU_CP0_EntryLo0);
        r_lo1 <= f_mask_lo(MMU_CP0_EntryLo1);
        r_pm  <= f_mask_pm(MMU_CP0_PageMask);
      end
      if (w_pr_ack) begin
        if (MMU_CP0_Matched) begin
          r_p   <= 1'b0;
          r_idx <= MMU_CP0_Index;
        end else begin
          r_p   <= 1'b1;
        end
      end
      if (MMU_CP0_Req) begin
        r_bv <= MMU_CP0_BadVAddr;
        r_hi <= {MMU_CP0_BadVAddr[31:13], 5'b0, r_hi[7:0]};
      end
    end
  end

  // Random free-runs downward, wrapping to the top when it meets Wired or Wired is rewritten.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_random <= LP_RTOP;
    end else if (w_wired_wr || (r_random == r_wired)) begin
      r_random <= LP_RTOP;
    end else begin
      r_random <= r_random - 3'd1;
    end
  end

  // Combinational Mfc0 read mux.
  always_comb begin
    Mfc0_Data = 32'd0;
    case (Mfc0_Sel)
      3'd0:    Mfc0_Data = {r_p, 28'd0, r_idx};
      3'd1:    Mfc0_Data = {29'd0, r_random};
      3'd2:    Mfc0_Data = r_lo0;
      3'd3:    Mfc0_Data = r_lo1;
      3'd4:    Mfc0_Data = r_pm;
      3'd5:    Mfc0_Data = {29'd0, r_wired};
      3'd6:    Mfc0_Data = r_bv;
      default: Mfc0_Data = r_hi;
    endcase
  end

  assign Op_Busy       = r_busy;
  assign Op_Done       = r_done;
  assign Op_Err        = r_err;
  assign CP0_RdReq     = r_rdreq;
  assign CP0_WrReq     = r_wrreq;
  assign CP0_MMU_Func  = r_func;
  assign CP0_MMU_Index = r_mmu_idx;
  assign CP0_EntryHi   = r_hi;
  assign CP0_EntryLo0  = r_lo0;
  assign CP0_EntryLo1  = r_lo1;
  assign CP0_PageMask  = r_pm;
  assign CP0_ASID      = r_hi[7:0];

endmodule
